// File: rtl/cmult_rr_sched.sv
// Round-robin scheduler sharing one 2-stage Q1.(W-1) complex multiplier among NCH requesters.
module cmult_rr_sched #(
  parameter int unsigned W   = 20,
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*2*W-1:0]   req_a,
  input  logic [NCH*2*W-1:0]   req_b,
  output logic [NCH-1:0]       req_ready,
  output logic                 res_valid,
  output logic [CW-1:0]        res_ch,
  output logic [2*W-1:0]       res_o,
  output logic                 busy,
  output logic [15:0]          grant_cnt
);

  localparam int unsigned DW = 2 * W;
  localparam int unsigned PW = 2 * W + 1;

  logic [CW-1:0]      ptr;
  logic [CW-1:0]      gidx;
  logic [CW-1:0]      ptr_nxt;
  logic               hit;
  logic [NCH-1:0]     grant;
  logic [2*NCH-1:0]   dbl;
  logic [NCH-1:0]     rot;
  logic [CW:0]        sum;
  logic               fire;
  logic [DW-1:0]      mux_a;
  logic [DW-1:0]      mux_b;

  logic               s1_valid;
  logic [DW-1:0]      s1_a;
  logic [DW-1:0]      s1_b;
  logic [CW-1:0]      s1_ch;

  logic signed [W-1:0]  a_i, a_q, b_i, b_q;
  logic signed [DW-1:0] p_ii, p_qq, p_qi, p_iq;
  logic signed [PW-1:0] p_i, p_q;
  logic [W-1:0]         o_i, o_q;
  logic                 unused_bits;

  // Round-robin search: rotate requests so ptr is bit 0, take the lowest set bit.
  always_comb begin
    dbl     = {req_valid, req_valid} >> ptr;
    rot     = dbl[NCH-1:0];
    hit     = 1'b0;
    sum     = '0;
    gidx    = '0;
    grant   = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        hit = 1'b1;
        sum = {1'b0, ptr} + (CW+1)'(j);
      end
    end
    if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
    gidx = sum[CW-1:0];
    for (int k = 0; k < NCH; k++) begin
      grant[k] = hit && (gidx == CW'(k));
    end
    ptr_nxt = (gidx == CW'(NCH - 1)) ? '0 : gidx + CW'(1);
  end

  // Grant is suppressed by reset or hold; a transfer happens whenever any ready is raised.
  always_comb begin
    req_ready = (rst || hold) ? '0 : grant;
    fire      = |req_ready;
  end

  // Select the granted channel's operands.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) begin
        mux_a = req_a[k*DW +: DW];
        mux_b = req_b[k*DW +: DW];
      end
    end
  end

  // Arbiter pointer and grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      grant_cnt <= '0;
    end else if (fire) begin
      ptr       <= ptr_nxt;
      grant_cnt <= grant_cnt + 16'd1;
    end
  end

  // Stage 1: capture operands and channel tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ch    <= '0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_a  <= mux_a;
        s1_b  <= mux_b;
        s1_ch <= gidx;
      end
    end
  end

  // Complex product with round-half-up and wrap to W bits.
  always_comb begin
    a_i  = s1_a[DW-1:W];
    a_q  = s1_a[W-1:0];
    b_i  = s1_b[DW-1:W];
    b_q  = s1_b[W-1:0];
    p_ii = DW'(a_i) * DW'(b_i);
    p_qq = DW'(a_q) * DW'(b_q);
    p_qi = DW'(a_q) * DW'(b_i);
    p_iq = DW'(a_i) * DW'(b_q);
    p_i  = PW'(p_ii) - PW'(p_qq);
    p_q  = PW'(p_qi) + PW'(p_iq);
    o_i  = p_i[DW-2:W-1] + W'(p_i[W-2]);
    o_q  = p_q[DW-2:W-1] + W'(p_q[W-2]);
  end

  assign unused_bits = ^{p_i[PW-1:DW-1], p_i[W-3:0], p_q[PW-1:DW-1], p_q[W-3:0],
                         dbl[2*NCH-1:NCH]};

  // Stage 2: result register; data holds while no result is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_o     <= '0;
      busy      <= 1'b0;
    end else begin
      res_valid <= s1_valid;
      busy      <= fire | s1_valid;
      if (s1_valid) begin
        res_o  <= {o_i, o_q};
        res_ch <= s1_ch;
      end
    end
  end

endmodule

// File: doc/cmult_rr_sched.md
Name: cmult_rr_sched

Overview:
- Time-shares one pipelined complex multiplier between NCH requesters, e.g. DPD basis-function and coefficient-apply stages.
- A round-robin arbiter grants at most one request per clock, and the granted operands enter a 2-stage multiply pipeline.
- Each result returns tagged with its channel index.
- Multiply arithmetic is the team's standard Q1.(W-1) complex product: round-half-up, wrap on overflow.

Parameters:
- W, 20, width of each I or Q component.
- NCH, 4, number of requesters, 2..8.
- CW, 3, channel tag width; must satisfy 2^CW >= NCH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  when 1, no new grant is issued; in-flight operations complete.
- req_valid  in  NCH  per-channel request.
- req_a  in  NCH*2*W  channel k operand A in bits [k*2W +: 2W], packed {I,Q}.
- req_b  in  NCH*2*W  channel k operand B, same packing.
- req_ready  out  NCH  one-hot grant; a transfer occurs when req_valid[k] & req_ready[k].
- res_valid  out  1  result valid.
- res_ch  out  CW  channel index of the result.
- res_o  out  2*W  product, packed {I,Q}.
- busy  out  1  1 while any operation is in flight.
- grant_cnt  out  16  total grants issued since reset; wraps modulo 2^16.

Behaviour:
- Reset (rst=1 at a clk edge):
  - req_ready, res_valid, res_ch, res_o and busy all 0.
  - grant_cnt=0 and round-robin pointer ptr=0.
  - All pipeline valid bits cleared; operations in flight are discarded, with no res_valid afterwards.
- req_ready is combinational from req_valid, ptr, hold and rst.
  - Grant goes to the first k with req_valid[k]=1, searching ptr, ptr+1, … mod NCH.
  - req_ready is all-zero when hold=1, rst=1, or no request is pending.
- Pointer: on a grant to channel k, ptr <= (k+1) mod NCH at the next edge; otherwise ptr is unchanged.
- Stage 1 (edge after grant): registers a, b, the channel tag and valid.
- Stage 2 (next edge): registers the complex product into res_o, the tag into res_ch, and res_valid.
- Latency: a grant in cycle n gives res_valid=1 in cycle n+2; results are in grant order.
- Throughput: 1 operation per clock; no output backpressure.
- When res_valid=0, res_o and res_ch hold their previous values.
- Arithmetic, with a_i/a_q/b_i/b_q signed W-bit:
  - P_i = a_i*b_i - a_q*b_q and P_q = a_q*b_i + a_i*b_q, each signed 2W+1 bit.
  - o_x = P_x[2W-2:W-1] + P_x[W-2], truncated to W bits (wrap, no saturation).
- busy = OR of the stage-1 and stage-2 valid bits.
- grant_cnt increments by 1 per accepted transfer; at 0xFFFF it wraps to 0.
- Simultaneous events:
  - A request deasserted in the same cycle it would be granted is not granted.
  - A channel may hold req_valid high continuously; it is regranted only after every other requesting channel has had a turn.
- hold asserted mid-stream:
  - No grant that cycle; ptr frozen.
  - Stages 1/2 drain, giving at most 2 further res_valid pulses; busy then drops.
- rst mid-operation: the pipeline is flushed as at reset, and the grant is suppressed in the same cycle.

Test Plan:
- Single op, W=20: ch2 requests a={0x40000,0x00000} (0.5+0j), b={0x40000,0x40000} (0.5+0.5j). Required: req_ready=0b0100 in cycle n; res_valid=1, res_ch=2, res_o={0x20000,0x20000} in cycle n+2.
- Rounding and wrap:
  - a=b={0x7FFFF,0}: res_o I=0x7FFFE, Q=0.
  - a=b={0x80000,0}: res_o I=0x80000 ((-1)*(-1) wraps), Q=0.
- Round-robin fairness: all 4 channels request continuously from reset. Required: grants ch0,1,2,3,0,1,… one per cycle; res_ch follows the same order 2 cycles later; grant_cnt=8 after 8 cycles.
- Sparse pointer: ptr=3 with only ch1 and ch2 requesting -> ch1 granted, then ch2, then ch1.
- hold/drain: hold=1 for 4 cycles during full load. Required: zero grants during hold; exactly 2 trailing res_valid pulses; busy=0 by the 3rd hold cycle; on release the grant resumes at the channel after the last granted one.
- Reset mid-flight: assert rst one cycle after a grant. Required: no res_valid for that op; busy=0, grant_cnt=0, ptr=0 afterwards.
